seq_divider: RTL and testbench

//  Sequential restoring divider: 2N-bit dividend / N-bit divisor -> 2N-bit quotient, N-bit remainder.

---
 rtl/seq_divider.sv | 117 +++++++++++
 tb/tb_seq_divider.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// ============================================================================
// seq_divider : restoring divider, 2N-bit dividend / N-bit divisor, 1 bit/clk
// Rev 1.0
// ============================================================================
`default_nettype none

module seq_divider #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           busy,
  output logic           done,
  output logic           div_by_zero,
  output logic [2*N-1:0] quotient,
  output logic [N-1:0]   remainder
);

  localparam int CW = $clog2(2*N);
  localparam logic [CW-1:0] CNT_LAST = CW'(2*N-1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [2*N-1:0] dvd;
  logic [N-1:0]   dsr;
  logic [N-1:0]   r;
  logic [2*N-1:0] q_sh;
  logic [CW-1:0]  cnt;

  logic [N:0]     r_shift;
  logic           ge;
  logic [N-1:0]   r_step;
  logic [2*N-1:0] q_step;

  // The partial remainder always ends each step below the divisor, so only
  // the shifted value needs the extra bit for the compare.
  always_comb begin
    r_shift = {r, dvd[2*N-1]};
    ge      = (r_shift >= {1'b0, dsr});
    r_step  = ge ? N'(r_shift - {1'b0, dsr}) : r_shift[N-1:0];
    q_step  = {q_sh[2*N-2:0], ge};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (divisor == '0) ? DONE : RUN;
      RUN:     if (cnt == CNT_LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dvd         <= '0;
      dsr         <= '0;
      r           <= '0;
      q_sh        <= '0;
      cnt         <= '0;
      div_by_zero <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= '0;
              div_by_zero <= 1'b1;
            end else begin
              dvd         <= dividend;
              dsr         <= divisor;
              r           <= '0;
              q_sh        <= '0;
              cnt         <= '0;
              div_by_zero <= 1'b0;
            end
          end
        end
        RUN: begin
          dvd  <= {dvd[2*N-2:0], 1'b0};
          r    <= r_step;
          q_sh <= q_step;
          cnt  <= cnt + 1'b1;
          // Results stay untouched until the final quotient bit is known.
          if (cnt == CNT_LAST) begin
            quotient  <= q_step;
            remainder <= r_step;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
// Testbench for seq_divider: directed cases, random ops and a full operand sweep
// against an arithmetic reference model.
`default_nettype none

module tb_seq_divider;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           start;
  logic [2*N-1:0] dividend;
  logic [N-1:0]   divisor;
  logic           busy;
  logic           done;
  logic           div_by_zero;
  logic [2*N-1:0] quotient;
  logic [N-1:0]   remainder;

  int checks   = 0;
  int failures = 0;

  logic [2*N-1:0] prev_q = '0;

  seq_divider #(.N(N)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .quotient    (quotient),
    .remainder   (remainder)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer division; divide-by-zero yields all-ones / 0.
  function automatic logic [31:0] ref_q(input int a, input int b);
    return (b == 0) ? (2**(2*N) - 1) : (a / b);
  endfunction

  function automatic logic [31:0] ref_r(input int a, input int b);
    return (b == 0) ? 0 : (a % b);
  endfunction

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  task automatic check_result(input int a, input int b);
    check("quotient", quotient, ref_q(a, b));
    check("remainder", remainder, ref_r(a, b));
    check("dbz", div_by_zero, (b == 0) ? 1 : 0);
    check("busy_at_done", busy, 0);
    if (b != 0) check("identity", quotient * b + remainder, a);
    prev_q = ref_q(a, b);
  endtask

  task automatic run_op(input int a, input int b);
    int cyc;
    dividend = a[2*N-1:0];
    divisor  = b[N-1:0];
    start    = 1'b1;
    tick();
    start = 1'b0;
    if (b != 0) begin
      check("dbz_clr", div_by_zero, 0);
      check("q_hold", quotient, prev_q);
      check("busy_run", busy, 1);
    end
    wait_done(cyc);
    check("latency", cyc, (b == 0) ? 0 : 2*N);
    check_result(a, b);
    tick();
    check("done_pulse", done, 0);
  endtask

  initial begin
    int cyc;
    reset_n  = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dbz", div_by_zero, 0);
    check("rst_q", quotient, 0);
    check("rst_r", remainder, 0);
    reset_n = 1'b1;
    tick();

    run_op(200, 7);
    run_op(255, 1);
    run_op(255, 15);
    run_op(5, 9);
    run_op(0, 3);
    run_op(100, 0);
    run_op(12, 4);

    // Reset during the third RUN cycle of 200/7.
    dividend = 8'd200; divisor = 4'd7; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("busy_pre_rst", busy, 1);
    reset_n = 1'b0;
    tick();
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_q", quotient, 0);
    check("mid_rst_r", remainder, 0);
    check("mid_rst_dbz", div_by_zero, 0);
    reset_n = 1'b1;
    prev_q  = '0;
    tick();

    // A start pulse with different operands during RUN must be ignored.
    dividend = 8'd60; divisor = 4'd7; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    dividend = 8'd1; divisor = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(cyc);
    check("ign_latency", cyc + 3, 2*N);
    check_result(60, 7);
    tick();

    // Start held high: second op accepted in the IDLE cycle after DONE.
    dividend = 8'd9; divisor = 4'd2; start = 1'b1;
    tick();
    wait_done(cyc);
    check("b2b_lat1", cyc, 2*N);
    check_result(9, 2);
    dividend = 8'd50; divisor = 4'd6;
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!done && cyc < 40);
    check("b2b_gap", cyc, 2*N + 2);
    check_result(50, 6);
    start = 1'b0;
    tick();

    for (int i = 0; i < 200; i++) begin
      run_op($urandom_range(2**(2*N) - 1), $urandom_range(2**N - 1));
    end

    for (int a = 0; a < 2**(2*N); a++) begin
      for (int b = 0; b < 2**N; b++) begin
        run_op(a, b);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
